// File: rtl/golden_eject_arbiter_if.sv
// Bus bundle between the crossbar input latches, the golden ejection arbiter and the local PE.
// The arbiter uses the slave view, and the requesters plus the PE side use the master view.
interface golden_eject_arbiter_if #(
   parameter int NUM_PORT = 4,
   parameter int DATA_W   = 64,
   parameter int TAG_W    = 16
);
   logic [TAG_W-1:0]           counterGolden;
   logic [NUM_PORT-1:0]        req_valid;
   logic [NUM_PORT*TAG_W-1:0]  req_tag;
   logic [NUM_PORT*DATA_W-1:0] req_data;
   logic [NUM_PORT-1:0]        grant;
   logic                       ej_valid;
   logic [DATA_W-1:0]          ej_data;
   logic [TAG_W-1:0]           ej_tag;
   logic                       ej_golden;
   logic                       ej_ready;

   modport master (
      output counterGolden, req_valid, req_tag, req_data, ej_ready,
      input  grant, ej_valid, ej_data, ej_tag, ej_golden
   );

   modport slave (
      input  counterGolden, req_valid, req_tag, req_data, ej_ready,
      output grant, ej_valid, ej_data, ej_tag, ej_golden
   );
endinterface

// File: rtl/golden_eject_arbiter.sv
// Local ejection arbiter: golden packet first, then starved ports, then round-robin,
// feeding a one-entry valid/ready output buffer toward the PE.
module golden_eject_arbiter #(
   parameter int NUM_PORT     = 4,
   parameter int DATA_W       = 64,
   parameter int STARVE_LIMIT = 15,
   parameter int TAG_W        = 16
) (
   input logic                   clk,
   input logic                   reset,
   golden_eject_arbiter_if.slave bus
);
   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
   localparam int PTR_W = (NUM_PORT > 1) ? $clog2(NUM_PORT) : 1;
   localparam logic [CNT_W-1:0]    CNT_MAX   = CNT_W'(STARVE_LIMIT);
   localparam logic [PTR_W-1:0]    PTR_LAST  = PTR_W'(NUM_PORT - 1);
   localparam logic [NUM_PORT-1:0] ONE_HOT_0 = {{(NUM_PORT-1){1'b0}}, 1'b1};

   logic [PTR_W-1:0]    rr_ptr;
   logic [CNT_W-1:0]    starve_cnt [NUM_PORT];
   logic [NUM_PORT-1:0] golden;
   logic [NUM_PORT-1:0] starved;
   logic [NUM_PORT-1:0] grant_vec;
   logic [PTR_W-1:0]    golden_idx;
   logic [PTR_W-1:0]    starved_idx;
   logic [PTR_W-1:0]    valid_idx;
   logic [PTR_W-1:0]    scan_idx;
   logic [PTR_W-1:0]    win_idx;
   logic                accept;
   logic                do_grant;
   logic                out_valid;
   logic [DATA_W-1:0]   out_data;
   logic [TAG_W-1:0]    out_tag;
   logic                out_golden;

   function automatic logic [PTR_W-1:0] rot_idx(input logic [PTR_W-1:0] base, input int offs);
      return PTR_W'((int'(base) + offs) % NUM_PORT);
   endfunction

   // Per-port class flags: golden tag match and starvation.
   always_comb begin
      golden  = {NUM_PORT{1'b0}};
      starved = {NUM_PORT{1'b0}};
      for (int i = 0; i < NUM_PORT; i++) begin
         golden[i]  = bus.req_valid[i] & (bus.req_tag[i*TAG_W +: TAG_W] == bus.counterGolden);
         starved[i] = bus.req_valid[i] & (starve_cnt[i] == CNT_MAX);
      end
   end

   // Winner selection and one-hot grant; scans run backwards so the earliest hit is kept.
   always_comb begin
      golden_idx  = {PTR_W{1'b0}};
      starved_idx = {PTR_W{1'b0}};
      valid_idx   = {PTR_W{1'b0}};
      scan_idx    = {PTR_W{1'b0}};
      for (int i = NUM_PORT - 1; i >= 0; i--) begin
         golden_idx = golden[i] ? PTR_W'(i) : golden_idx;
      end
      for (int k = NUM_PORT - 1; k >= 0; k--) begin
         scan_idx    = rot_idx(rr_ptr, k);
         starved_idx = starved[scan_idx] ? scan_idx : starved_idx;
         valid_idx   = bus.req_valid[scan_idx] ? scan_idx : valid_idx;
      end
      win_idx   = (|golden) ? golden_idx : ((|starved) ? starved_idx : valid_idx);
      accept    = ~out_valid | bus.ej_ready;
      do_grant  = reset & accept & (|bus.req_valid);
      grant_vec = do_grant ? (ONE_HOT_0 << win_idx) : {NUM_PORT{1'b0}};
   end

   // Output buffer and round-robin pointer; a grant reloads even while the PE drains.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_valid  <= 1'b0;
         out_data   <= {DATA_W{1'b0}};
         out_tag    <= {TAG_W{1'b0}};
         out_golden <= 1'b0;
         rr_ptr     <= {PTR_W{1'b0}};
      end else if (do_grant) begin
         out_valid  <= 1'b1;
         out_data   <= bus.req_data[win_idx*DATA_W +: DATA_W];
         out_tag    <= bus.req_tag[win_idx*TAG_W +: TAG_W];
         out_golden <= golden[win_idx];
         rr_ptr     <= (win_idx == PTR_LAST) ? {PTR_W{1'b0}} : win_idx + 1'b1;
      end else if (bus.ej_ready) begin
         out_valid  <= 1'b0;
      end else begin
         out_valid  <= out_valid;
      end
   end

   // Consecutive-loss counters, saturating at the starvation limit.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NUM_PORT; i++) begin
            starve_cnt[i] <= {CNT_W{1'b0}};
         end
      end else begin
         for (int i = 0; i < NUM_PORT; i++) begin
            if (grant_vec[i] | ~bus.req_valid[i]) begin
               starve_cnt[i] <= {CNT_W{1'b0}};
            end else if (starve_cnt[i] != CNT_MAX) begin
               starve_cnt[i] <= starve_cnt[i] + 1'b1;
            end else begin
               starve_cnt[i] <= starve_cnt[i];
            end
         end
      end
   end

   assign bus.grant     = grant_vec;
   assign bus.ej_valid  = out_valid;
   assign bus.ej_data   = out_data;
   assign bus.ej_tag    = out_tag;
   assign bus.ej_golden = out_golden;
endmodule

// File: tb/tb_golden_eject_arbiter.sv
// Directed bench for golden_eject_arbiter: reset, round-robin, golden override,
// backpressure, starvation and asynchronous reset mid-transfer.
module tb_golden_eject_arbiter;
   localparam int NP = 4;
   localparam int DW = 64;
   localparam int TW = 16;
   localparam int SL = 3;
   localparam logic [TW-1:0] NO_MATCH = 16'hFFFF;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   errors = 0;

   logic [TW-1:0] tag_tab  [NP];
   logic [DW-1:0] data_tab [NP];

   golden_eject_arbiter_if #(.NUM_PORT(NP), .DATA_W(DW), .TAG_W(TW)) bus ();

   golden_eject_arbiter #(
      .NUM_PORT(NP), .DATA_W(DW), .STARVE_LIMIT(SL), .TAG_W(TW)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      tag_tab[0]  = 16'h1100;
      tag_tab[1]  = 16'h2211;
      tag_tab[2]  = 16'h3322;
      tag_tab[3]  = 16'h4433;
      data_tab[0] = 64'hD0D0_0000_0000_0A00;
      data_tab[1] = 64'hD1D1_1111_0000_0A01;
      data_tab[2] = 64'hD2D2_2222_0000_0A02;
      data_tab[3] = 64'hD3D3_3333_0000_0A03;
      for (int i = 0; i < NP; i++) begin
         bus.req_tag[i*TW +: TW]  = tag_tab[i];
         bus.req_data[i*DW +: DW] = data_tab[i];
      end
      bus.counterGolden = NO_MATCH;
      bus.req_valid     = 4'hF;
      bus.ej_ready      = 1'b1;

      // reset held low with every port requesting
      #1 reset = 1'b0;
      #2;
      check("rst_grant",  bus.grant,     4'b0000);
      check("rst_valid",  bus.ej_valid,  1'b0);
      check("rst_data",   bus.ej_data,   64'h0);
      check("rst_tag",    bus.ej_tag,    16'h0);
      check("rst_golden", bus.ej_golden, 1'b0);
      tick();
      tick();
      check("rst_hold_grant", bus.grant,    4'b0000);
      check("rst_hold_valid", bus.ej_valid, 1'b0);

      // round-robin with wrap, first grant in the first cycle out of reset
      reset = 1'b1;
      for (int k = 0; k < 5; k++) begin
         #1 check("rr_grant", bus.grant, 4'b0001 << (k % 4));
         tick();
         check("rr_valid", bus.ej_valid, 1'b1);
         check("rr_data",  bus.ej_data,  data_tab[k % 4]);
      end

      // bring rr_ptr back to 0, then golden override
      bus.req_valid = 4'b1000;
      #1 check("align_grant", bus.grant, 4'b1000);
      tick();
      bus.req_valid     = 4'hF;
      bus.counterGolden = 16'h3322;
      #1 check("gold_grant", bus.grant, 4'b0100);
      tick();
      check("gold_flag", bus.ej_golden, 1'b1);
      check("gold_tag",  bus.ej_tag,    16'h3322);
      check("gold_data", bus.ej_data,   data_tab[2]);
      bus.counterGolden = NO_MATCH;
      #1 check("gold_rrptr", bus.grant, 4'b1000);
      bus.req_tag[3*TW +: TW] = 16'h2211;
      bus.counterGolden       = 16'h2211;
      #1 check("gold_multi", bus.grant, 4'b0010);
      tick();
      check("gold_multi_data", bus.ej_data,   data_tab[1]);
      check("gold_multi_flag", bus.ej_golden, 1'b1);
      bus.req_tag[3*TW +: TW] = tag_tab[3];
      bus.counterGolden       = NO_MATCH;

      // backpressure: buffer must hold, then reload on the release cycle
      bus.ej_ready  = 1'b0;
      bus.req_valid = 4'b0001;
      for (int k = 0; k < 5; k++) begin
         #1 check("bp_grant", bus.grant, 4'b0000);
         tick();
         check("bp_valid", bus.ej_valid, 1'b1);
         check("bp_data",  bus.ej_data,  data_tab[1]);
         check("bp_tag",   bus.ej_tag,   16'h2211);
      end
      check("bp_sat", dut.starve_cnt[0], 3);
      bus.ej_ready = 1'b1;
      #1 check("bp_release", bus.grant, 4'b0001);
      tick();
      check("bp_new_data",   bus.ej_data,   data_tab[0]);
      check("bp_new_tag",    bus.ej_tag,    16'h1100);
      check("bp_new_golden", bus.ej_golden, 1'b0);
      check("bp_clear",      dut.starve_cnt[0], 0);

      // starvation beats round-robin (rr_ptr moved to 2 first)
      bus.req_valid = 4'b0010;
      #1 check("st_align", bus.grant, 4'b0010);
      tick();
      bus.ej_ready = 1'b0;
      repeat (3) tick();
      check("st_cnt", dut.starve_cnt[1], 3);
      bus.ej_ready  = 1'b1;
      bus.req_valid = 4'b1110;
      #1 check("st_grant", bus.grant, 4'b0010);
      tick();
      check("st_clear", dut.starve_cnt[1], 0);
      check("st_data",  bus.ej_data, data_tab[1]);

      // golden beats starved
      bus.ej_ready  = 1'b0;
      bus.req_valid = 4'b0010;
      repeat (3) tick();
      check("gvs_pre_cnt", dut.starve_cnt[1], 3);
      bus.ej_ready      = 1'b1;
      bus.req_valid     = 4'b1010;
      bus.counterGolden = 16'h4433;
      #1 check("gvs_grant", bus.grant, 4'b1000);
      tick();
      check("gvs_cnt",    dut.starve_cnt[1], 3);
      check("gvs_golden", bus.ej_golden, 1'b1);
      check("gvs_tag",    bus.ej_tag,    16'h4433);

      // asynchronous reset while a flit is buffered
      bus.ej_ready      = 1'b0;
      bus.counterGolden = NO_MATCH;
      #2 reset = 1'b0;
      #1;
      check("arst_valid",  bus.ej_valid,  1'b0);
      check("arst_data",   bus.ej_data,   64'h0);
      check("arst_tag",    bus.ej_tag,    16'h0);
      check("arst_golden", bus.ej_golden, 1'b0);
      check("arst_grant",  bus.grant,     4'b0000);
      check("arst_cnt",    dut.starve_cnt[1], 0);
      tick();
      reset         = 1'b1;
      bus.req_valid = 4'b0100;
      bus.ej_ready  = 1'b1;
      #1 check("post_rst_grant", bus.grant, 4'b0100);
      tick();
      check("post_rst_valid", bus.ej_valid, 1'b1);
      check("post_rst_data",  bus.ej_data,  data_tab[2]);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
